// File: rtl/ip_pwm_mixer.sv
// Three-channel sample scheduler and saturating mixer feeding ip_pwm's signal_level.
// Each enable strobe runs one fixed five-cycle pass: accumulate x3, saturate, slew.
module ip_pwm_mixer #(
  parameter int unsigned SLEW = 16'd4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        ch0_valid,
  input  logic [15:0] ch0_data,
  output logic        ch0_ready,
  input  logic        ch1_valid,
  input  logic [15:0] ch1_data,
  output logic        ch1_ready,
  input  logic        ch2_valid,
  input  logic [15:0] ch2_data,
  output logic        ch2_ready,
  input  logic        cfg_wr,
  input  logic [1:0]  cfg_addr,
  input  logic [4:0]  cfg_wdata,
  output logic [15:0] signal_level,
  output logic        busy,
  output logic        overrun
);

  typedef enum logic [2:0] {StIdle, StAcc0, StAcc1, StAcc2, StSat, StSlew} state_e;

  localparam logic [16:0] SlewStep = 17'(SLEW);

  state_e             r_state, w_state_next;
  logic [2:0]         r_full;
  logic [15:0]        r_sample [3];
  logic [4:0]         r_vol [3];
  logic               r_mute;
  logic signed [17:0] r_acc;
  logic [15:0]        r_target;
  logic [15:0]        r_level;
  logic               r_overrun;

  logic [2:0]         w_valid;
  logic [15:0]        w_data [3];
  logic [2:0]         w_accept;
  logic [2:0]         w_consume;
  logic [1:0]         w_sel;
  logic signed [15:0] w_samp;
  logic signed [5:0]  w_volx;
  logic signed [21:0] w_prod;
  logic signed [21:0] w_term;
  logic signed [17:0] w_acc_sum;
  logic [15:0]        w_clamp;
  logic [15:0]        w_target_calc;
  logic signed [16:0] w_diff;
  logic [15:0]        w_level_next;
  logic [4:0]         w_vol_wr;

  assign w_valid   = {ch2_valid, ch1_valid, ch0_valid};
  assign w_data[0] = ch0_data;
  assign w_data[1] = ch1_data;
  assign w_data[2] = ch2_data;
  assign w_accept  = w_valid & ~r_full;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (enable) w_state_next = StAcc0;
      StAcc0:  w_state_next = StAcc1;
      StAcc1:  w_state_next = StAcc2;
      StAcc2:  w_state_next = StSat;
      StSat:   w_state_next = StSlew;
      StSlew:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // Output / decode logic
  always_comb begin
    busy      = (r_state != StIdle);
    w_consume = 3'b000;
    w_sel     = 2'd0;
    unique case (r_state)
      StAcc0:  begin w_consume = 3'b001; w_sel = 2'd0; end
      StAcc1:  begin w_consume = 3'b010; w_sel = 2'd1; end
      StAcc2:  begin w_consume = 3'b100; w_sel = 2'd2; end
      default: ;
    endcase
  end

  assign w_samp    = $signed(r_sample[w_sel]);
  assign w_volx    = $signed({1'b0, r_vol[w_sel]});
  assign w_prod    = 22'(w_samp) * 22'(w_volx);
  assign w_term    = w_prod >>> 4;
  assign w_acc_sum = r_acc + $signed(w_term[17:0]);

  always_comb begin
    if (r_acc > 18'sd32767) begin
      w_clamp = 16'h7FFF;
    end else if (r_acc < -18'sd32768) begin
      w_clamp = 16'h8000;
    end else begin
      w_clamp = r_acc[15:0];
    end
    w_target_calc = r_mute ? 16'h8000 : (w_clamp ^ 16'h8000);
  end

  assign w_diff = $signed({1'b0, r_target}) - $signed({1'b0, r_level});

  always_comb begin
    if (w_diff > $signed(SlewStep)) begin
      w_level_next = r_level + SlewStep[15:0];
    end else if (w_diff < -$signed(SlewStep)) begin
      w_level_next = r_level - SlewStep[15:0];
    end else begin
      w_level_next = r_target;
    end
  end

  assign w_vol_wr = (cfg_wdata > 5'd16) ? 5'd16 : cfg_wdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_full    <= 3'b000;
      r_mute    <= 1'b0;
      r_acc     <= '0;
      r_target  <= 16'h8000;
      r_level   <= 16'h8000;
      r_overrun <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        r_sample[i] <= 16'h0000;
        r_vol[i]    <= 5'd16;
      end
    end else begin
      r_overrun <= enable & busy;
      // A channel read in its ACC slot uses the held sample; a same-cycle capture lands next pass.
      for (int i = 0; i < 3; i++) begin
        if (w_accept[i]) begin
          r_sample[i] <= w_data[i];
          r_full[i]   <= 1'b1;
        end else if (w_consume[i]) begin
          r_full[i] <= 1'b0;
        end
        if (cfg_wr && (cfg_addr == 2'(i))) begin
          r_vol[i] <= w_vol_wr;
        end
      end
      if (cfg_wr && (cfg_addr == 2'd3)) begin
        r_mute <= cfg_wdata[0];
      end
      unique case (r_state)
        StIdle:                 if (enable) r_acc <= '0;
        StAcc0, StAcc1, StAcc2: r_acc <= w_acc_sum;
        StSat:                  r_target <= w_target_calc;
        StSlew:                 r_level <= w_level_next;
        default: ;
      endcase
    end
  end

  assign ch0_ready    = ~r_full[0];
  assign ch1_ready    = ~r_full[1];
  assign ch2_ready    = ~r_full[2];
  assign signal_level = r_level;
  assign overrun      = r_overrun;

endmodule

// File: tb/tb_ip_pwm_mixer.sv
// Self-checking bench for ip_pwm_mixer: directed and random passes against an arithmetic model,
// run on a default-slew instance and a SLEW=65535 instance driven in lockstep.
module tb_ip_pwm_mixer;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        cfg_wr;
  logic [1:0]  cfg_addr;
  logic [4:0]  cfg_wdata;
  logic [2:0]  valid;
  logic [15:0] data [3];
  logic [2:0]  rdy, rdy_f;
  logic [15:0] lvl, lvl_f;
  logic        busy, busy_f, ovr, ovr_f;

  int n_checks = 0;
  int n_errors = 0;

  int m_samp [3];
  int m_vol  [3];
  bit m_mute;
  int m_lvl, m_lvl_f;

  always #5 clk = ~clk;

  ip_pwm_mixer dut (
    .clk(clk), .reset(reset), .enable(enable),
    .ch0_valid(valid[0]), .ch0_data(data[0]), .ch0_ready(rdy[0]),
    .ch1_valid(valid[1]), .ch1_data(data[1]), .ch1_ready(rdy[1]),
    .ch2_valid(valid[2]), .ch2_data(data[2]), .ch2_ready(rdy[2]),
    .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .signal_level(lvl), .busy(busy), .overrun(ovr)
  );

  ip_pwm_mixer #(.SLEW(65535)) dut_fast (
    .clk(clk), .reset(reset), .enable(enable),
    .ch0_valid(valid[0]), .ch0_data(data[0]), .ch0_ready(rdy_f[0]),
    .ch1_valid(valid[1]), .ch1_data(data[1]), .ch1_ready(rdy_f[1]),
    .ch2_valid(valid[2]), .ch2_data(data[2]), .ch2_ready(rdy_f[2]),
    .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .signal_level(lvl_f), .busy(busy_f), .overrun(ovr_f)
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int slew_to(input int cur, input int tgt, input int step);
    if (tgt - cur > step) return cur + step;
    if (cur - tgt > step) return cur - step;
    return tgt;
  endfunction

  function automatic int mix_target();
    int sum = 0;
    for (int i = 0; i < 3; i++) sum += (m_samp[i] * m_vol[i]) >>> 4;
    if (sum > 32767) sum = 32767;
    if (sum < -32768) sum = -32768;
    return m_mute ? 32768 : sum + 32768;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_samp[i] = 0;
      m_vol[i]  = 16;
    end
    m_mute  = 1'b0;
    m_lvl   = 32768;
    m_lvl_f = 32768;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_lvl"}, lvl, 16'h8000);
    chk({tag, "_lvlf"}, lvl_f, 16'h8000);
    chk({tag, "_busy"}, 16'(busy), 16'd0);
    chk({tag, "_ovr"}, 16'(ovr), 16'd0);
    chk({tag, "_rdy"}, 16'(rdy), 16'h7);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    check_reset_vals("rst");
    tick();
    reset = 1'b0;
    model_reset();
  endtask

  task automatic offer(input int ch, input logic [15:0] d);
    valid[ch] = 1'b1;
    data[ch]  = d;
    chk("offer_rdy", 16'(rdy[ch]), 16'd1);
    tick();
    valid[ch] = 1'b0;
    chk("capt_rdy", 16'(rdy[ch]), 16'd0);
    m_samp[ch] = int'($signed(d));
  endtask

  task automatic cfg(input logic [1:0] addr, input logic [4:0] d);
    cfg_wr    = 1'b1;
    cfg_addr  = addr;
    cfg_wdata = d;
    tick();
    cfg_wr = 1'b0;
    if (addr == 2'd3) m_mute = d[0];
    else m_vol[addr] = (d > 5'd16) ? 16 : int'(d);
  endtask

  // hold1: ch1_valid stays high through the pass, so ch1 refills right after its ACC slot.
  task automatic run_pass(input bit hold1);
    int tgt;
    enable = 1'b1;
    tick();
    enable = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("busy", 16'(busy), 16'd1);
      chk("held", lvl, 16'(m_lvl));
      chk("ovr0", 16'(ovr), 16'd0);
      if (hold1) chk("rdy1_trace", 16'(rdy[1]), 16'(k == 2));
      tick();
    end
    tgt     = mix_target();
    m_lvl   = slew_to(m_lvl, tgt, 4096);
    m_lvl_f = slew_to(m_lvl_f, tgt, 65535);
    if (hold1) m_samp[1] = int'($signed(data[1]));
    chk("idle", 16'(busy), 16'd0);
    chk("level", lvl, 16'(m_lvl));
    chk("level_fast", lvl_f, 16'(m_lvl_f));
    chk("rdy_after", 16'(rdy), hold1 ? 16'h5 : 16'h7);
  endtask

  initial begin
    int exp_ramp;
    reset = 1'b0; enable = 1'b0; cfg_wr = 1'b0; cfg_addr = 2'd0; cfg_wdata = 5'd0;
    valid = 3'b000;
    for (int i = 0; i < 3; i++) data[i] = 16'h0000;
    model_reset();
    #2;
    do_reset();

    // Idle passes with no samples
    for (int p = 0; p < 3; p++) begin
      run_pass(1'b0);
      tick(); tick();
    end
    chk("idle_level", lvl, 16'h8000);

    offer(0, 16'h4000);
    run_pass(1'b0);
    chk("half_fast", lvl_f, 16'hC000);
    chk("half_slow", lvl, 16'h9000);

    // Positive saturation and ramp
    do_reset();
    for (int i = 0; i < 3; i++) offer(i, 16'h7FFF);
    for (int k = 1; k <= 8; k++) begin
      run_pass(1'b0);
      exp_ramp = 32768 + 4096 * k;
      if (exp_ramp > 65535) exp_ramp = 65535;
      chk("ramp_up", lvl, 16'(exp_ramp));
      chk("sat_hi", lvl_f, 16'hFFFF);
    end
    cfg(2'd3, 5'd1);
    for (int k = 0; k < 9; k++) run_pass(1'b0);
    chk("mute_down", lvl, 16'h8000);
    chk("mute_fast", lvl_f, 16'h8000);
    cfg(2'd3, 5'd0);
    for (int i = 0; i < 3; i++) offer(i, 16'h8000);
    run_pass(1'b0);
    chk("sat_lo", lvl_f, 16'h0000);

    // Volume scaling and clamp
    do_reset();
    cfg(2'd0, 5'd8);
    offer(0, 16'h2000);
    run_pass(1'b0);
    chk("vol8", lvl_f, 16'h9000);
    cfg(2'd0, 5'd31);
    run_pass(1'b0);
    chk("vol31", lvl_f, 16'hA000);

    // Randomized passes
    for (int it = 0; it < 24; it++) begin
      if ($urandom_range(0, 1) == 1) cfg(2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)));
      for (int i = 0; i < 3; i++) if ($urandom_range(0, 2) != 0) offer(i, 16'($urandom));
      run_pass(1'b0);
    end
    cfg(2'd3, 5'd0);

    // ch1 valid held: one sample per pass
    valid[1] = 1'b1;
    data[1]  = 16'h1111;
    tick();
    chk("hold_capt", 16'(rdy[1]), 16'd0);
    m_samp[1] = int'($signed(16'h1111));
    data[1] = 16'h2222;
    run_pass(1'b1);
    data[1] = 16'h3333;
    run_pass(1'b1);
    valid[1] = 1'b0;
    run_pass(1'b0);

    // Overrun: enable two cycles into a pass
    offer(0, 16'h6000);
    enable = 1'b1; tick();
    enable = 1'b0; tick();
    enable = 1'b1; tick();
    enable = 1'b0;
    chk("ovr_pulse", 16'(ovr), 16'd1);
    tick();
    chk("ovr_gone", 16'(ovr), 16'd0);
    tick(); tick();
    m_lvl   = slew_to(m_lvl, mix_target(), 4096);
    m_lvl_f = slew_to(m_lvl_f, mix_target(), 65535);
    chk("ovr_idle", 16'(busy), 16'd0);
    chk("ovr_level", lvl_f, 16'(m_lvl_f));
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("no_second", 16'(busy), 16'd0);
      chk("no_second_lvl", lvl, 16'(m_lvl));
    end

    // Reset mid-pass
    offer(1, 16'h5000);
    enable = 1'b1; tick();
    enable = 1'b0; tick();
    valid[2] = 1'b1;
    data[2]  = 16'h1234;
    tick();
    valid[2] = 1'b0;
    chk("mid_rdy2", 16'(rdy[2]), 16'd0);
    do_reset();
    tick();
    run_pass(1'b0);
    chk("post_rst", lvl_f, 16'h8000);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
